// File: rtl/intersection_phase_scheduler.sv
// Demand-actuated highway/side-road phase scheduler with round-robin request arbitration.
// Define PED_CROSSING_EN to compile in the pedestrian crossing (ped_pend, last_srv, PED_WALK).
module intersection_phase_scheduler #(
  parameter int unsigned HWY_GREEN_MIN = 16,
  parameter int unsigned SIDE_GREEN    = 8,
  parameter int unsigned YELLOW        = 3,
  parameter int unsigned ALL_RED       = 2,
  parameter int unsigned WALK          = 6,
  parameter int unsigned CNT_W         = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] highway,
  output logic [2:0] side_road,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    StHwyG    = 3'd0,
    StHwyY    = 3'd1,
    StClr1    = 3'd2,
    StSideG   = 3'd3,
    StSideY   = 3'd4,
    StClr2    = 3'd5,
    StPedWalk = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] HwyLast  = CNT_W'(HWY_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] SideLast = CNT_W'(SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] YelLast  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] RedLast  = CNT_W'(ALL_RED - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             side_pend_q, side_pend_d;
  logic             side_dem, grant_side, hwy_exit, take_grant;
  logic [2:0]       highway_d, side_road_d;
  logic             walk_d;

`ifdef PED_CROSSING_EN
  localparam logic [CNT_W-1:0] WalkLast = CNT_W'(WALK - 1);
  logic ped_pend_q, ped_pend_d;
  logic last_ped_q, last_ped_d;  // last_srv: 1 = pedestrian served last
  logic ped_dem;
`else
  logic unused_ped_req;
  assign unused_ped_req = ped_req;
`endif

  always_comb begin
    side_dem = side_pend_q | side_req;
`ifdef PED_CROSSING_EN
    ped_dem    = ped_pend_q | ped_req;
    hwy_exit   = (cnt_q == HwyLast) && (side_dem || ped_dem);
    grant_side = side_dem && (!ped_dem || last_ped_q);
`else
    hwy_exit   = (cnt_q == HwyLast) && side_dem;
    grant_side = side_dem;
`endif
    take_grant = (state_q == StHwyG) && hwy_exit;

    state_d = state_q;
    unique case (state_q)
      StHwyG:  if (hwy_exit) state_d = StHwyY;
      StHwyY:  if (cnt_q == YelLast) state_d = StClr1;
      StClr1: begin
        if (cnt_q == RedLast) begin
`ifdef PED_CROSSING_EN
          // last_ped_q was updated on the grant edge, so it names the current grantee
          state_d = last_ped_q ? StPedWalk : StSideG;
`else
          state_d = StSideG;
`endif
        end
      end
      StSideG: if (cnt_q == SideLast) state_d = StSideY;
      StSideY: if (cnt_q == YelLast) state_d = StClr2;
      StClr2:  if (cnt_q == RedLast) state_d = StHwyG;
`ifdef PED_CROSSING_EN
      StPedWalk: if (cnt_q == WalkLast) state_d = StClr2;
`endif
      default: state_d = StHwyG;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StHwyG && cnt_q == HwyLast) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    side_pend_d = (side_pend_q | (side_req && state_q != StSideG && state_q != StSideY))
                  & ~(take_grant & grant_side);
`ifdef PED_CROSSING_EN
    ped_pend_d = (ped_pend_q | (ped_req && state_q != StPedWalk)) & ~(take_grant & ~grant_side);
    last_ped_d = take_grant ? ~grant_side : last_ped_q;
`endif

    highway_d   = 3'b100;
    side_road_d = 3'b100;
    walk_d      = 1'b0;
    unique case (state_d)
      StHwyG:    highway_d   = 3'b001;
      StHwyY:    highway_d   = 3'b010;
      StSideG:   side_road_d = 3'b001;
      StSideY:   side_road_d = 3'b010;
`ifdef PED_CROSSING_EN
      StPedWalk: walk_d      = 1'b1;
`endif
      default:   ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StHwyG;
      cnt_q       <= '0;
      side_pend_q <= 1'b0;
`ifdef PED_CROSSING_EN
      ped_pend_q  <= 1'b0;
      last_ped_q  <= 1'b1;
`endif
      highway     <= 3'b001;
      side_road   <= 3'b100;
      walk        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      side_pend_q <= side_pend_d;
`ifdef PED_CROSSING_EN
      ped_pend_q  <= ped_pend_d;
      last_ped_q  <= last_ped_d;
`endif
      highway     <= highway_d;
      side_road   <= side_road_d;
      walk        <= walk_d;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: expected per-cycle {phase, highway, side_road, walk} queued, then compared.
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       side_req = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] highway, side_road, phase;
  logic       walk;
  logic [9:0] obs;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [9:0]  exp_q[$];

  intersection_phase_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .side_req  (side_req),
    .ped_req   (ped_req),
    .highway   (highway),
    .side_road (side_road),
    .walk      (walk),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  assign obs = {phase, highway, side_road, walk};

  function automatic logic [9:0] expect_vec(input logic [2:0] ph);
    case (ph)
      3'd0:    return {3'd0, 3'b001, 3'b100, 1'b0};
      3'd1:    return {3'd1, 3'b010, 3'b100, 1'b0};
      3'd2:    return {3'd2, 3'b100, 3'b100, 1'b0};
      3'd3:    return {3'd3, 3'b100, 3'b001, 1'b0};
      3'd4:    return {3'd4, 3'b100, 3'b010, 1'b0};
      3'd5:    return {3'd5, 3'b100, 3'b100, 1'b0};
      3'd6:    return {3'd6, 3'b100, 3'b100, 1'b1};
      default: return 10'h3ff;
    endcase
  endfunction

  task automatic push_seg(input logic [2:0] ph, input int n);
    repeat (n) exp_q.push_back(expect_vec(ph));
  endtask

  // Leaves rst released on a falling edge, one sample before the first active edge.
  task automatic do_reset();
    side_req = 1'b0;
    ped_req  = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== expect_vec(3'd0)) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=%b", obs, expect_vec(3'd0));
    end
  endtask

  task automatic test_idle();
    logic [9:0] e;
    int k = 0;
    do_reset();
    push_seg(3'd0, 201);
    while (exp_q.size() > 0) begin
      if (k > 0) @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL idle k=%0d got=%b want=%b", k, obs, e);
      end
      k++;
    end
  endtask

  task automatic test_single_side();
    logic [9:0] e;
    int k = 0;
    do_reset();
    push_seg(3'd0, 16); push_seg(3'd1, 3); push_seg(3'd2, 2); push_seg(3'd3, 8);
    push_seg(3'd4, 3);  push_seg(3'd5, 2); push_seg(3'd0, 12);
    while (exp_q.size() > 0) begin
      if (k > 0) @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL single_side k=%0d got=%b want=%b", k, obs, e);
      end
      side_req = (k == 2);
      k++;
    end
    side_req = 1'b0;
  endtask

  // Late request gives 1-cycle latency; a second pulse during SIDE_G must be dropped.
  task automatic test_late_request();
    logic [9:0] e;
    int k = 0;
    do_reset();
    push_seg(3'd0, 41); push_seg(3'd1, 3); push_seg(3'd2, 2); push_seg(3'd3, 8);
    push_seg(3'd4, 3);  push_seg(3'd5, 2); push_seg(3'd0, 30);
    while (exp_q.size() > 0) begin
      if (k > 0) @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL late_request k=%0d got=%b want=%b", k, obs, e);
      end
      side_req = (k == 40) || (k == 48);
      k++;
    end
    side_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [9:0] e;
    int k = 0;
    do_reset();
    push_seg(3'd0, 16); push_seg(3'd1, 3); push_seg(3'd2, 2); push_seg(3'd3, 4);
    while (exp_q.size() > 0) begin
      if (k > 0) @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_pre k=%0d got=%b want=%b", k, obs, e);
      end
      side_req = (k == 2);
      ped_req  = (k == 2);
      k++;
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== expect_vec(3'd0)) begin
      n_fail++;
      $display("FAIL reset_mid_async got=%b want=%b", obs, expect_vec(3'd0));
    end
    @(negedge clk);
    rst = 1'b1;
    push_seg(3'd0, 60);
    k = 0;
    while (exp_q.size() > 0) begin
      if (k > 0) @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid_hold k=%0d got=%b want=%b", k, obs, e);
      end
      k++;
    end
  endtask

`ifdef PED_CROSSING_EN
  task automatic test_back_to_back();
    logic [9:0] e;
    int k = 0;
    do_reset();
    push_seg(3'd0, 16); push_seg(3'd1, 3); push_seg(3'd2, 2); push_seg(3'd3, 8);
    push_seg(3'd4, 3);  push_seg(3'd5, 2); push_seg(3'd0, 16); push_seg(3'd1, 3);
    push_seg(3'd2, 2);  push_seg(3'd6, 6); push_seg(3'd5, 2);  push_seg(3'd0, 12);
    while (exp_q.size() > 0) begin
      if (k > 0) @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL tie k=%0d got=%b want=%b", k, obs, e);
      end
      side_req = (k == 2);
      ped_req  = (k == 2);
      k++;
    end
    side_req = 1'b0;
    ped_req  = 1'b0;
  endtask
`else
  task automatic test_ped_ignored();
    logic [9:0] e;
    int k = 0;
    do_reset();
    push_seg(3'd0, 101);
    while (exp_q.size() > 0) begin
      if (k > 0) @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL ped_ignored k=%0d got=%b want=%b", k, obs, e);
      end
      ped_req = (k % 5 == 2);
      k++;
    end
    ped_req = 1'b0;
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_idle();
    test_single_side();
    test_late_request();
    test_reset_mid();
`ifdef PED_CROSSING_EN
    test_back_to_back();
`else
    test_ped_ignored();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
# intersection_phase_scheduler

Demand-actuated phase scheduler for a highway/side-road intersection with an optional pedestrian crossing. Highway rests on green; side-road vehicle and pedestrian requests are latched, arbitrated round-robin, and served one per cycle of the signal plan. It drives the `highway` and `side_road` lamp buses plus `walk`, with every phase duration set by a parameter.

## Interface
- `HWY_GREEN_MIN`, 16: minimum highway green, in cycles.
- `SIDE_GREEN`, 8: side-road green, in cycles.
- `YELLOW`, 3: yellow duration, both roads, in cycles.
- `ALL_RED`, 2: all-red clearance, in cycles.
- `WALK`, 6: pedestrian walk duration, in cycles.
- `CNT_W`, 5: phase counter width. Must satisfy 2^CNT_W > max(all durations). All durations must be ≥ 1.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset. Asynchronous, active-low.
- `side_req`  in  1: side-road vehicle sensor (level). Sampled every cycle.
- `ped_req`  in  1: pedestrian button. A 1-cycle pulse is sufficient.
- `highway`  out  3: {red, yellow, green}, one-hot, registered.
- `side_road`  out  3: {red, yellow, green}, one-hot, registered.
- `walk`  out  1: pedestrian walk lamp, registered.
- `phase`  out  3: current state encoding, for debug and status.

## Operation
- States and `phase` codes: HWY_G=0, HWY_Y=1, CLR1=2, SIDE_G=3, SIDE_Y=4, CLR2=5, PED_WALK=6.
- Lamps by state:
  - HWY_G: highway=001, side_road=100.
  - HWY_Y: highway=010, side_road=100.
  - SIDE_G: highway=100, side_road=001.
  - SIDE_Y: highway=100, side_road=010.
  - CLR1, CLR2, PED_WALK: both roads 100.
  - walk=1 only in PED_WALK.
- Counter `cnt` is cleared on every state transition and increments each cycle.
- A timed state of duration D exits when `cnt==D-1`, so it lasts exactly D cycles.
- In HWY_G, `cnt` saturates at HWY_GREEN_MIN-1.
- Pending flags:
  - `side_pend` sets when `side_req`=1 in any state except SIDE_G and SIDE_Y.
  - `ped_pend` sets when `ped_req`=1 in any state except PED_WALK.
- HWY_G exit condition: `cnt` saturated AND (pend | live req) for either requester.
- Grant on HWY_G→HWY_Y:
  - Exactly one requester demanding: grant it.
  - Both demanding: grant the one that is not `last_srv`.
  - Clear the granted requester's pending flag; the other flag stays set.
  - Update `last_srv`.
- Sequences:
  - Side grant: HWY_G → HWY_Y → CLR1 → SIDE_G → SIDE_Y → CLR2 → HWY_G.
  - Ped grant: HWY_G → HWY_Y → CLR1 → PED_WALK → CLR2 → HWY_G.
- One grant per highway cycle. The ungranted requester is served after the next full HWY_GREEN_MIN.
- Unreachable `phase` codes recover to HWY_G on the next edge.

## Timing
- Reset asserted (asynchronous):
  - state=HWY_G, cnt=0, highway=001, side_road=100, walk=0, phase=0.
  - side_pend=0, ped_pend=0, last_srv=ped, so side wins the first tie.
- Reset mid-phase: lamps go to reset values immediately, without waiting for a clock edge. Pending requests are discarded.
- Lamps and `phase` are registered and change on the same edge as the state change.
- A request arriving after `cnt` has saturated in HWY_G: HWY_Y begins on the next edge (1-cycle latency).
- A request arriving earlier is held pending until HWY_GREEN_MIN elapses.
- Fixed service cycle after HWY_G exit:
  - Side: YELLOW+ALL_RED+SIDE_G+YELLOW+ALL_RED = 18 cycles at defaults.
  - Ped: YELLOW+ALL_RED+WALK+ALL_RED = 13 cycles at defaults.
- Requests asserted during their own service phase are dropped, not queued.

## Configuration
- `PED_CROSSING_EN` defined:
  - Pedestrian logic compiled in: `ped_pend`, `last_srv` and the PED_WALK state.
- `PED_CROSSING_EN` undefined:
  - `ped_req` is ignored and `walk` is tied 0.
  - PED_WALK is absent; only side-road requests are arbitrated.
  - Port list is unchanged.

## Test plan
- **Idle:** release `rst`, no requests for 200 cycles → highway=001, side_road=100, walk=0, phase=0 throughout.
- **Single side request:** one-cycle `side_req` pulse 2 cycles after reset release →
  - HWY_G for 16 cycles, HWY_Y 3, CLR1 2, SIDE_G 8, SIDE_Y 3, CLR2 2.
  - HWY_G re-entered 34 cycles after reset release.
- **Late request:** `side_req` at cycle 40 of an idle HWY_G → phase=1 and highway=010 on the next edge.
- **Tie:** `side_req` and `ped_req` both pulsed in the first HWY_G →
  - SIDE_G is served first, then HWY_G for exactly 16 cycles.
  - Then PED_WALK with walk=1 for 6 cycles.
- **Reset mid-phase:** `rst` low during cycle 4 of SIDE_G, with `ped_pend` set →
  - Lamps become 001/100 asynchronously.
  - After release with no new requests, HWY_G holds indefinitely.
- **Macro off** (`PED_CROSSING_EN` undefined): repeated `ped_req` pulses → walk never 1, phase never 6, highway stays 001.
